cfg_streamer: RTL
=================

CFG_STREAMER -- requirements
Module: cfg_streamer

Interface
REQ-001 SHALL have parameter CONF_WIDTH, default 5906, the total bits in the target tile's configuration chain.
REQ-002 SHALL have parameter WORD_W, default 32, the width of each source word.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a load.
REQ-006 SHALL have port word_in  in  WORD_W  configuration word from the source.
REQ-007 SHALL have port word_valid  in  1  word_in is valid.
REQ-008 SHALL have port word_ready  out  1  streamer accepts word_in this cycle.
REQ-009 SHALL have port cen  out  1  chain shift enable; drives the tile's cen.
REQ-010 SHALL have port shift_out  out  1  serial configuration bit; drives the tile's shift_in.
REQ-011 SHALL have port cset  out  1  configuration latch strobe; drives the tile's cset.
REQ-012 SHALL have ports busy  out  1 (load in progress) and done  out  1 (one-cycle completion pulse).
REQ-013 SHALL have port crc  out  16  CRC of the emitted bits.

Function
REQ-014 SHALL implement FSM IDLE -> SHIFT (on start) -> LATCH (after the final bit) -> DONE (1 cycle) -> IDLE.
REQ-015 SHALL ignore start in any state other than IDLE.
REQ-016 SHALL consume NWORDS = ceil(CONF_WIDTH/WORD_W) words per load; a word transfers on a cycle with word_valid && word_ready.
REQ-017 SHALL emit each word LSB first; in the final word only the low CONF_WIDTH mod WORD_W bits are emitted (all WORD_W bits when the remainder is 0), and the rest are discarded.
REQ-018 SHALL register cen and shift_out, so that on every cycle with cen=1 shift_out carries exactly one valid chain bit.
REQ-019 SHALL assert word_ready only in SHIFT, with fewer than NWORDS words accepted, and the bit buffer either empty or on its last bit; this gives zero bubbles when word_valid is held high.
REQ-020 SHALL drive cen=0 and hold the bit count when the buffer is empty (source stall); no bit may be lost or duplicated.
REQ-021 SHALL produce exactly CONF_WIDTH cen cycles per load.
REQ-022 SHALL, in LATCH, drive cset=1 for exactly one cycle with cen=0; this is the cycle after the last cen=1 cycle.
REQ-023 SHALL pulse done for one cycle in DONE, the cycle after cset.
REQ-024 SHALL keep busy=1 from the cycle after start is accepted through DONE inclusive.
REQ-025 SHALL start a new load when start arrives in the same cycle as DONE is exited, and not earlier.

Reset
REQ-026 SHALL, on rst=0 at any time including mid-load, force state IDLE, clear counters and buffer, and drive cen, cset, shift_out, word_ready, busy, done to 0 and crc to 0xFFFF (0x0000 without the macro).
REQ-027 SHALL, after a mid-load reset, restart a subsequent load from bit 0 with no residual state.

Configuration
REQ-028 SHALL, with CFG_CRC_EN defined, compute serial CRC-16-CCITT (poly 0x1021, init 0xFFFF):
- updated with shift_out on each cen=1 cycle;
- re-initialised when start is accepted;
- held after DONE.
REQ-029 SHALL, without CFG_CRC_EN, tie crc to 0x0000 and instantiate no CRC logic.

Structure
REQ-030 SHALL place the FSM state enum, the CRC polynomial and init constants, and the default CONF_WIDTH in shared package cfg_pkg.
REQ-031 SHALL implement the CRC as sub-module cfg_crc16_serial, instantiated only under CFG_CRC_EN.

Verification (bench: CONF_WIDTH=40, WORD_W=32)
REQ-032 SHALL cover: rst=0 asserted mid-cycle -> all outputs 0 immediately, without waiting for clk.
REQ-033 SHALL cover: start, then words 0xCAFEBABE and 0x000000A5 with valid held high ->
- 40 consecutive cen cycles;
- shift_out = 0xCAFEBABE LSB-first, then 1,0,1,0,0,1,0,1;
- cset one cycle later, then done one cycle after that.
REQ-034 SHALL cover: word_valid low for 5 cycles between words -> cen low for those 5 cycles, 40 total cen cycles, identical bit sequence.
REQ-035 SHALL cover: rst=0 after 17 bits, then a new start -> full 40-bit sequence from bit 0 and a single cset.
REQ-036 SHALL cover: start pulsed during SHIFT -> no effect; exactly one cset and one done.
REQ-037 SHALL cover: with CFG_CRC_EN, 40 zero bits -> crc matches the bench bit-serial model; without the macro -> crc=0x0000 throughout.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-chain streamer: FSM states,
// CRC-16-CCITT constants and the default chain length.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_e;

  localparam int unsigned CONF_WIDTH_DEFAULT = 5906;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT (MSB-first shift register, poly 0x1021).
// The register is re-initialised by init and advanced by one bit when en=1.
module cfg_crc16_serial
  import cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  // Next CRC value: init has priority over a data bit.
  always_comb begin
    fb    = crc_q[15] ^ bit_in;
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

  // CRC register, reset to the init value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/cfg_streamer.sv
// Configuration-chain streamer: accepts WORD_W-bit words from a source and
// shifts CONF_WIDTH bits LSB-first into a tile's configuration chain, then
// strobes cset and pulses done.
// Optional feature: define CFG_CRC_EN to compute a CRC-16-CCITT over the
// emitted bits; otherwise crc is tied to 0x0000.
module cfg_streamer
  import cfg_pkg::*;
#(
  parameter int unsigned CONF_WIDTH = CONF_WIDTH_DEFAULT,
  parameter int unsigned WORD_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cen,
  output logic              shift_out,
  output logic              cset,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc
);

  localparam int unsigned NWORDS    = ceil_div(CONF_WIDTH, WORD_W);
  localparam int unsigned REM_BITS  = CONF_WIDTH % WORD_W;
  localparam int unsigned LAST_BITS = (REM_BITS == 0) ? WORD_W : REM_BITS;
  localparam int unsigned CW        = $clog2(WORD_W + 1);
  localparam int unsigned WCW       = $clog2(NWORDS + 1);

  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(WORD_W);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(LAST_BITS);
  localparam logic [WCW-1:0] WORDS_ALL = WCW'(NWORDS);
  localparam logic [WCW-1:0] WORDS_PEN = WCW'(NWORDS - 1);
  localparam logic [WCW-1:0] WORDS_ONE = WCW'(1);

  cfg_state_e        state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [CW-1:0]     cnt_q, cnt_d;     // bits still held in buf_q
  logic [WCW-1:0]    words_q, words_d; // words accepted this load
  logic              cen_q, cen_d;
  logic              sout_q, sout_d;

  // Next-state, buffer and handshake logic.
  // A new word may be loaded in the same cycle the last buffered bit is
  // emitted, so a continuously valid source produces no cen gaps. The FSM
  // leaves SHIFT one cycle after the final emit decision, which is the
  // cycle the registered cen shows the final bit; cset follows it.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    cen_d      = 1'b0;
    sout_d     = 1'b0;
    word_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          buf_d   = '0;
          cnt_d   = '0;
          words_d = '0;
        end
      end
      ST_SHIFT: begin
        word_ready = (words_q != WORDS_ALL) && (cnt_q <= CNT_ONE);
        if (cnt_q != '0) begin
          cen_d  = 1'b1;
          sout_d = buf_q[0];
          buf_d  = buf_q >> 1;
          cnt_d  = cnt_q - CNT_ONE;
        end
        if (word_ready && word_valid) begin
          buf_d   = word_in;
          cnt_d   = (words_q == WORDS_PEN) ? CNT_LAST : CNT_FULL;
          words_d = words_q + WORDS_ONE;
        end
        if ((words_q == WORDS_ALL) && (cnt_q == '0)) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      cen_q   <= 1'b0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      cen_q   <= cen_d;
      sout_q  <= sout_d;
    end
  end

  assign cen       = cen_q;
  assign shift_out = sout_q;
  assign cset      = (state_q == ST_LATCH);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

`ifdef CFG_CRC_EN
  cfg_crc16_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .init   ((state_q == ST_IDLE) && start),
    .en     (cen_q),
    .bit_in (sout_q),
    .crc    (crc)
  );
`else
  assign crc = 16'h0000;
`endif

endmodule
